educell_ctrl: RTL and testbench
===============================

# educell_ctrl

Per-cell sequencing controller for the error-decoding-unit (EDU) spike mesh. It captures the measured syndrome and boundary configuration at round start, then drives `state`, `delayed_esmval`, `delayed_bdval`, `spike_taken` and `spikedir_reg` into the cell's spike generator. It arbitrates the six neighbour spike inputs, forwards the first arrival exactly once, and reports a match when a spike reaches an emitting cell.

## Interface
Parameters:
- `EMIT_DELAY`, default 2: cycles from round start to source/boundary emission, range 1–15.
- `AQMEAS_TH`, default `` `AQMEAS_TH ``: syndrome measurement width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `round_start`  in  1  one-cycle pulse that begins a decode round.
- `round_clear`  in  1  one-cycle pulse that aborts or ends a round and returns the cell to IDLE.
- `esm_in`  in  AQMEAS_TH  syndrome measurement, sampled on `round_start`.
- `bd_en`  in  1  cell is a boundary cell, sampled on `round_start`.
- `spike_in`  in  6  neighbour spikes {nw,ne,sw,se,n,s}, bit 5 = nw.
- `state`  out  3  EDUCELL state code.
- `delayed_esmval`  out  AQMEAS_TH  captured syndrome; nonzero only in the emission cycle.
- `delayed_bdval`  out  1  boundary emission pulse.
- `spike_taken`  out  1  forward pulse.
- `spikedir_reg`  out  6  output direction mask, same bit order as `spike_in`.
- `match_valid`  out  1  one-cycle match pulse.
- `match_dir`  out  6  one-hot arrival direction of the matching spike; held until clear.

## Operation
States (3-bit, `` `EDUCELL_* ``): IDLE=0, SOURCE=1, BOUNDARY=2, TRANSMIT=3, DONE=4.

Transitions:
- IDLE + `round_start`:
  - if `|esm_in`: SOURCE;
  - else if `bd_en`: BOUNDARY;
  - else: TRANSMIT.
- SOURCE / BOUNDARY:
  - a 4-bit delay counter loads `EMIT_DELAY` on entry and decrements to 0.
  - In the cycle the counter reaches 0, emit one pulse: `delayed_esmval = esm_reg` in SOURCE, or `delayed_bdval = 1` in BOUNDARY.
  - The emission cycle uses `spikedir_reg = 6'b111111`.
  - After emission, any `spike_in` bit produces `match_valid` and `match_dir = winner`, then DONE.
  - Spikes that arrive before emission are latched as a match immediately. The emission is suppressed and the cell goes to DONE.
- TRANSMIT:
  - the first cycle with `|spike_in` selects a winner by fixed priority nw>ne>sw>se>n>s.
  - Next cycle: `spike_taken = 1` for one cycle, with `spikedir_reg = ~winner`.
  - The cycle after that: DONE.
- DONE: ignores `spike_in`; holds `match_dir`.
- `round_clear` in any state: IDLE. It clears `esm_reg`, `spikedir_reg`, `match_dir` and the counter.
- Priority: `rst` > `round_clear` > `round_start`. `round_start` outside IDLE is ignored.

Outputs zero outside their defined cycles: `delayed_esmval`, `delayed_bdval`, `spike_taken`, `match_valid`.

## Timing
- All outputs are registered. Reset value of every output: 0, with `state` = IDLE.
- `round_start` at cycle T gives `state` valid at T+1. Emission occurs at T+1+EMIT_DELAY.
- TRANSMIT: `spike_in` at cycle T gives `spike_taken` at T+1 and DONE at T+2. End-to-end hop latency is 1 cycle.
- Match: `spike_in` at cycle T gives `match_valid` at T+1 (a pulse) and DONE at T+1.
- Simultaneous multi-bit `spike_in`: only the highest-priority bit is taken; the others are dropped.
- `rst` or `round_clear` asserted during an emission or forward cycle: the outputs of the next cycle are zero.

## Structure
- State codes `EDUCELL_IDLE`/`SOURCE`/`BOUNDARY`/`TRANSMIT`/`DONE` and `AQMEAS_TH` live in `define.v`.
- One sub-module, `educell_prio6`: a combinational 6-bit fixed-priority one-hot picker, shared by the match and forward paths.
- `educell_ctrl` drives the existing spike-generator instance directly. The per-cell wrapper instantiates both.

## Test plan
- `round_start` with `esm_in = 1`, `EMIT_DELAY = 2` at T=0 → SOURCE at T=1; `delayed_esmval = 1` and `spikedir_reg = 6'b111111` only at T=3.
- TRANSMIT cell, `spike_in = 6'b000100` (se) at T → `spike_taken` at T+1 with `spikedir_reg = 6'b111011`; DONE at T+2; a later `spike_in = 6'b000001` gives no response.
- TRANSMIT cell, `spike_in = 6'b010011` → winner ne, so `spikedir_reg = 6'b101111`.
- SOURCE cell after emission, `spike_in = 6'b000010` → `match_valid` pulse, `match_dir = 6'b000010`, DONE.
- `bd_en = 1`, `esm_in = 0` → BOUNDARY; `delayed_bdval` pulses at T+1+EMIT_DELAY. A spike at T+1 instead produces a match and suppresses the emission.
- `round_clear` and `round_start` in the same cycle while in TRANSMIT → IDLE, all outputs 0. `rst` mid-countdown → IDLE, no emission.

Source files
------------

// File: rtl/educell_pkg.sv
// educell_pkg: state codes and default syndrome width for the EDU cell controller
package educell_pkg;
    localparam int EDUCELL_AQMEAS_TH = 4;
    typedef enum logic [2:0] {
        EDUCELL_IDLE     = 3'd0,
        EDUCELL_SOURCE   = 3'd1,
        EDUCELL_BOUNDARY = 3'd2,
        EDUCELL_TRANSMIT = 3'd3,
        EDUCELL_DONE     = 3'd4
    } educell_state_e;
endpackage

// File: rtl/educell_if.sv
// educell_if: round control, neighbour spikes and spike-generator drive for one EDU cell
interface educell_if import educell_pkg::*; #(parameter int AQMEAS_TH = EDUCELL_AQMEAS_TH) ();
    logic                 round_start;
    logic                 round_clear;
    logic [AQMEAS_TH-1:0] esm_in;
    logic                 bd_en;
    logic [5:0]           spike_in;
    logic [2:0]           state;
    logic [AQMEAS_TH-1:0] delayed_esmval;
    logic                 delayed_bdval;
    logic                 spike_taken;
    logic [5:0]           spikedir_reg;
    logic                 match_valid;
    logic [5:0]           match_dir;
    modport master (
        output round_start, round_clear, esm_in, bd_en, spike_in,
        input  state, delayed_esmval, delayed_bdval, spike_taken, spikedir_reg, match_valid, match_dir
    );
    modport slave (
        input  round_start, round_clear, esm_in, bd_en, spike_in,
        output state, delayed_esmval, delayed_bdval, spike_taken, spikedir_reg, match_valid, match_dir
    );
endinterface

// File: rtl/educell_prio6.sv
// educell_prio6: one-hot fixed-priority picker, bit 5 (nw) highest
module educell_prio6 (
    input  logic [5:0] req_i,
    output logic [5:0] win_o
);
    always_comb begin
        win_o = '0;
        for (int i = 0; i < 6; i++)
            if (req_i[i]) win_o = 6'd1 << i;
    end
endmodule

// File: rtl/educell_ctrl.sv
// educell_ctrl: per-cell round sequencer driving the spike generator and reporting matches
module educell_ctrl import educell_pkg::*; #(
    parameter int EMIT_DELAY = 2,
    parameter int AQMEAS_TH  = EDUCELL_AQMEAS_TH
) (
    input logic       clk,
    input logic       rst,
    educell_if.slave  bus
);
    educell_state_e       state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [AQMEAS_TH-1:0] esm_q, esm_d, esmval_q, esmval_d;
    logic                 bdval_q, bdval_d, taken_q, taken_d, match_q, match_d;
    logic [5:0]           dir_q, dir_d, mdir_q, mdir_d, win;

    educell_prio6 u_prio (.req_i(bus.spike_in), .win_o(win));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EDUCELL_IDLE;
            cnt_q    <= '0;
            esm_q    <= '0;
            esmval_q <= '0;
            bdval_q  <= 1'b0;
            taken_q  <= 1'b0;
            match_q  <= 1'b0;
            dir_q    <= '0;
            mdir_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            esm_q    <= esm_d;
            esmval_q <= esmval_d;
            bdval_q  <= bdval_d;
            taken_q  <= taken_d;
            match_q  <= match_d;
            dir_q    <= dir_d;
            mdir_q   <= mdir_d;
        end
    end

    // Outputs are registered, so emission is decided while the counter still reads 1.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        esm_d    = esm_q;
        esmval_d = '0;
        bdval_d  = 1'b0;
        taken_d  = 1'b0;
        match_d  = 1'b0;
        dir_d    = '0;
        mdir_d   = mdir_q;
        if (bus.round_clear) begin
            state_d = EDUCELL_IDLE;
            cnt_d   = '0;
            esm_d   = '0;
            mdir_d  = '0;
        end else begin
            case (state_q)
                EDUCELL_IDLE: if (bus.round_start) begin
                    esm_d   = bus.esm_in;
                    cnt_d   = 4'(EMIT_DELAY);
                    state_d = |bus.esm_in ? EDUCELL_SOURCE : bus.bd_en ? EDUCELL_BOUNDARY : EDUCELL_TRANSMIT;
                end
                EDUCELL_SOURCE, EDUCELL_BOUNDARY: if (|bus.spike_in) begin
                    match_d = 1'b1;
                    mdir_d  = win;
                    state_d = EDUCELL_DONE;
                end else if (cnt_q == 4'd1) begin
                    esmval_d = (state_q == EDUCELL_SOURCE) ? esm_q : '0;
                    bdval_d  = state_q == EDUCELL_BOUNDARY;
                    dir_d    = '1;
                end
                EDUCELL_TRANSMIT: if (taken_q) begin
                    state_d = EDUCELL_DONE;
                end else if (|bus.spike_in) begin
                    taken_d = 1'b1;
                    dir_d   = ~win;
                end
                default: ;
            endcase
        end
    end

    assign bus.state          = state_q;
    assign bus.delayed_esmval = esmval_q;
    assign bus.delayed_bdval  = bdval_q;
    assign bus.spike_taken    = taken_q;
    assign bus.spikedir_reg   = dir_q;
    assign bus.match_valid    = match_q;
    assign bus.match_dir      = mdir_q;
endmodule

// File: tb/tb_educell_ctrl.sv
// tb_educell_ctrl: directed vector table plus reset corner sequences for educell_ctrl
module tb_educell_ctrl;
    typedef struct packed {
        logic        st;
        logic        cl;
        logic [3:0]  esm;
        logic        bd;
        logic [5:0]  sp;
        logic [21:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vt [32];
    logic [21:0] obs;

    always #5 clk = ~clk;

    educell_if #(.AQMEAS_TH(4)) bus ();
    educell_ctrl #(.EMIT_DELAY(2), .AQMEAS_TH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign obs = {bus.state, bus.delayed_esmval, bus.delayed_bdval, bus.spike_taken,
                  bus.spikedir_reg, bus.match_valid, bus.match_dir};

    function automatic vec_t mk(logic st, logic cl, logic [3:0] esm, logic bd, logic [5:0] sp,
                                logic [2:0] s, logic [3:0] ev, logic bv, logic tk,
                                logic [5:0] dir, logic mv, logic [5:0] md);
        vec_t v;
        v.st = st; v.cl = cl; v.esm = esm; v.bd = bd; v.sp = sp;
        v.exp = {s, ev, bv, tk, dir, mv, md};
        return v;
    endfunction

    task automatic chk(input string name, input logic [21:0] got, input logic [21:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic cl, input logic [3:0] esm, input logic bd, input logic [5:0] sp);
        @(negedge clk);
        bus.round_start = st;
        bus.round_clear = cl;
        bus.esm_in      = esm;
        bus.bd_en       = bd;
        bus.spike_in    = sp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // source round: ignored second start, emission at T+3, match, DONE holds, clear
        vt[0]  = mk(1,0,4'h1,0,6'h00, 3'd1,4'h0,0,0,6'h00,0,6'h00);
        vt[1]  = mk(1,0,4'hF,1,6'h00, 3'd1,4'h0,0,0,6'h00,0,6'h00);
        vt[2]  = mk(0,0,4'h0,0,6'h00, 3'd1,4'h1,0,0,6'h3F,0,6'h00);
        vt[3]  = mk(0,0,4'h0,0,6'h00, 3'd1,4'h0,0,0,6'h00,0,6'h00);
        vt[4]  = mk(0,0,4'h0,0,6'b000010, 3'd4,4'h0,0,0,6'h00,1,6'b000010);
        vt[5]  = mk(0,0,4'h0,0,6'h00, 3'd4,4'h0,0,0,6'h00,0,6'b000010);
        vt[6]  = mk(0,0,4'h0,0,6'b100000, 3'd4,4'h0,0,0,6'h00,0,6'b000010);
        vt[7]  = mk(0,1,4'h0,0,6'h00, 3'd0,4'h0,0,0,6'h00,0,6'h00);
        // transmit se, later spikes ignored
        vt[8]  = mk(1,0,4'h0,0,6'h00, 3'd3,4'h0,0,0,6'h00,0,6'h00);
        vt[9]  = mk(0,0,4'h0,0,6'b000100, 3'd3,4'h0,0,1,6'b111011,0,6'h00);
        vt[10] = mk(0,0,4'h0,0,6'b000001, 3'd4,4'h0,0,0,6'h00,0,6'h00);
        vt[11] = mk(0,0,4'h0,0,6'b000001, 3'd4,4'h0,0,0,6'h00,0,6'h00);
        vt[12] = mk(0,1,4'h0,0,6'h00, 3'd0,4'h0,0,0,6'h00,0,6'h00);
        // transmit multi-bit: ne wins
        vt[13] = mk(1,0,4'h0,0,6'h00, 3'd3,4'h0,0,0,6'h00,0,6'h00);
        vt[14] = mk(0,0,4'h0,0,6'b010011, 3'd3,4'h0,0,1,6'b101111,0,6'h00);
        vt[15] = mk(0,0,4'h0,0,6'h00, 3'd4,4'h0,0,0,6'h00,0,6'h00);
        vt[16] = mk(0,1,4'h0,0,6'h00, 3'd0,4'h0,0,0,6'h00,0,6'h00);
        // boundary emission
        vt[17] = mk(1,0,4'h0,1,6'h00, 3'd2,4'h0,0,0,6'h00,0,6'h00);
        vt[18] = mk(0,0,4'h0,0,6'h00, 3'd2,4'h0,0,0,6'h00,0,6'h00);
        vt[19] = mk(0,0,4'h0,0,6'h00, 3'd2,4'h0,1,0,6'h3F,0,6'h00);
        vt[20] = mk(0,0,4'h0,0,6'h00, 3'd2,4'h0,0,0,6'h00,0,6'h00);
        vt[21] = mk(0,1,4'h0,0,6'h00, 3'd0,4'h0,0,0,6'h00,0,6'h00);
        // boundary with early spike: match, emission suppressed
        vt[22] = mk(1,0,4'h0,1,6'h00, 3'd2,4'h0,0,0,6'h00,0,6'h00);
        vt[23] = mk(0,0,4'h0,0,6'b001000, 3'd4,4'h0,0,0,6'h00,1,6'b001000);
        vt[24] = mk(0,0,4'h0,0,6'h00, 3'd4,4'h0,0,0,6'h00,0,6'b001000);
        vt[25] = mk(0,1,4'h0,0,6'h00, 3'd0,4'h0,0,0,6'h00,0,6'h00);
        // clear beats start in TRANSMIT; clear during emission cycle
        vt[26] = mk(1,0,4'h0,0,6'h00, 3'd3,4'h0,0,0,6'h00,0,6'h00);
        vt[27] = mk(1,1,4'h0,0,6'h00, 3'd0,4'h0,0,0,6'h00,0,6'h00);
        vt[28] = mk(1,0,4'hA,0,6'h00, 3'd1,4'h0,0,0,6'h00,0,6'h00);
        vt[29] = mk(0,0,4'h0,0,6'h00, 3'd1,4'h0,0,0,6'h00,0,6'h00);
        vt[30] = mk(0,0,4'h0,0,6'h00, 3'd1,4'hA,0,0,6'h3F,0,6'h00);
        vt[31] = mk(0,1,4'h0,0,6'h00, 3'd0,4'h0,0,0,6'h00,0,6'h00);

        bus.round_start = 1'b0;
        bus.round_clear = 1'b0;
        bus.esm_in      = '0;
        bus.bd_en       = 1'b0;
        bus.spike_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", obs, 22'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive(vt[i].st, vt[i].cl, vt[i].esm, vt[i].bd, vt[i].sp);
            chk($sformatf("vec%0d", i), obs, vt[i].exp);
        end

        // reset mid-countdown: back to IDLE and no emission afterwards
        drive(1, 0, 4'h1, 0, 6'h00);
        chk("rst_pre_state", obs, {3'd1, 19'h0});
        @(negedge clk);
        bus.round_start = 1'b0;
        bus.esm_in      = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid", obs, 22'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst_quiet%0d", i), obs, 22'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
